// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic library (adder / subtractor).
//   state_e : FSM encoding shared by the serial arithmetic blocks.
//             ST_DONE is also used by the serial subtractor, so keep the
//             encodings stable.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder, purely combinational.
//   a, b, cin : operand bits and carry-in
//   s, cout   : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, LSB first, one bit per clock,
// using one full-adder cell and a registered carry.
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, accepted in IDLE or DONE
//   a, b, cin       : operands, captured when start is accepted
//   busy            : high while shifting
//   done            : one-cycle pulse; sum/cout valid from this cycle on
//   sum, cout       : result registers, hold the last completed result
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  import serial_arith_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_sr_q, acc_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_s, fa_c;
  logic accept;
  logic last_bit;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // DONE accepts a new request exactly like IDLE so ops can run back to back.
  assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_bit = (count_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_d = ST_DONE;
      ST_DONE:  state_d = accept ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic (Moore)
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
  end

  // Datapath next-state
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    acc_sr_d = acc_sr_q;
    carry_d  = carry_q;
    count_d  = count_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    if (accept) begin
      a_sr_d  = a;
      b_sr_d  = b;
      carry_d = cin;
      count_d = '0;
    end else if (state_q == ST_SHIFT) begin
      // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at bit 0.
      acc_sr_d = {fa_s, acc_sr_q[WIDTH-1:1]};
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      carry_d  = fa_c;
      count_d  = count_q + CW'(1);
      // Result registers update only on the final bit so they hold the
      // previous result for the whole shift.
      if (last_bit) begin
        sum_d  = {fa_s, acc_sr_q[WIDTH-1:1]};
        cout_d = fa_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      acc_sr_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      acc_sr_q <= acc_sr_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a WIDTH=8 instance for directed and
// random traffic, and a WIDTH=4 instance for an exhaustive sweep.
module tb_serial_adder;

  typedef struct {
    logic [8:0] res;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // WIDTH=8 instance
  logic       rst8 = 1'b1, start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  // WIDTH=4 instance
  logic       rst4 = 1'b1, start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a request is taken whenever the unit is free, i.e. not
  // within WIDTH cycles of the previous acceptance; the answer is plain
  // a+b+cin, due WIDTH edges after acceptance.
  exp_t q8[$], q4[$];
  int   free8 = 0, free4 = 0;
  int   last8 = 0, last4 = 0;
  bit   act8 = 0, act4 = 0;
  logic [8:0] held8 = '0;
  logic [4:0] held4 = '0;

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst8) begin
      q8.delete(); act8 = 0; free8 = cyc + 1; held8 = '0;
    end else if (start8 && cyc >= free8) begin
      e.res = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
      e.due = cyc + 8;
      q8.push_back(e);
      act8 = 1; last8 = cyc; free8 = cyc + 9;
    end
    if (rst4) begin
      q4.delete(); act4 = 0; free4 = cyc + 1; held4 = '0;
    end else if (start4 && cyc >= free4) begin
      e.res = {5'd0, {1'b0, a4} + {1'b0, b4} + {4'd0, cin4}};
      e.due = cyc + 4;
      q4.push_back(e);
      act4 = 1; last4 = cyc; free4 = cyc + 5;
    end
  end

  // Monitor: compares outputs against the scoreboard on the falling edge.
  bit pd8 = 0, pd4 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      check("busy8", 32'(busy8), 32'(act8 && cyc >= last8 && cyc <= last8 + 7));
      if (done8) begin
        check("done8_single_pulse", 32'(pd8), 32'(0));
        if (q8.size() == 0) check("done8_unexpected", 32'(1), 32'(0));
        else begin
          e = q8.pop_front();
          check("done8_cycle", 32'(cyc), 32'(e.due));
          held8 = e.res;
        end
      end else if (q8.size() > 0 && q8[0].due <= cyc) begin
        check("done8_missing", 32'(0), 32'(1));
        void'(q8.pop_front());
      end
      check("sum8", 32'(sum8), 32'(held8[7:0]));
      check("cout8", 32'(cout8), 32'(held8[8]));
      pd8 = done8;

      check("busy4", 32'(busy4), 32'(act4 && cyc >= last4 && cyc <= last4 + 3));
      if (done4) begin
        check("done4_single_pulse", 32'(pd4), 32'(0));
        if (q4.size() == 0) check("done4_unexpected", 32'(1), 32'(0));
        else begin
          e = q4.pop_front();
          check("done4_cycle", 32'(cyc), 32'(e.due));
          held4 = e.res[4:0];
        end
      end else if (q4.size() > 0 && q4[0].due <= cyc) begin
        check("done4_missing", 32'(0), 32'(1));
        void'(q4.pop_front());
      end
      check("sum4", 32'(sum4), 32'(held4[3:0]));
      check("cout4", 32'(cout4), 32'(held4[4]));
      pd4 = done4;
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk); a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; a8 = $urandom; b8 = $urandom; cin8 = 1'($urandom);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    fork
      begin : drv8
        repeat (3) @(negedge clk);
        rst8 = 1'b0;
        op8(8'h5A, 8'h3C, 1'b0);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1);
        // Start pulsed again mid-shift must be ignored.
        @(negedge clk); a8 = 8'h23; b8 = 8'h45; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'h11; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (10) @(negedge clk);
        // Reset during the fourth shift cycle aborts the op.
        @(negedge clk); a8 = 8'h77; b8 = 8'h99; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk); rst8 = 1'b0;
        repeat (12) @(negedge clk);
        // Start held high: back-to-back results.
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        repeat (40) @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
          start8 = ($urandom_range(0, 3) == 0);
          a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
          rst8 = ($urandom_range(0, 99) == 0);
          @(negedge clk);
        end
        start8 = 1'b0; rst8 = 1'b0;
        repeat (12) @(negedge clk);
      end
      begin : drv4
        repeat (3) @(negedge clk);
        rst4 = 1'b0;
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            for (int c = 0; c < 2; c++) begin
              @(negedge clk); a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); start4 = 1'b1;
              @(negedge clk); start4 = 1'b0;
              repeat (4) @(negedge clk);
            end
        repeat (8) @(negedge clk);
      end
    join
    check("q8_drained", 32'(q8.size()), 32'(0));
    check("q4_drained", 32'(q4.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
